// File: rtl/dense_input_framer.sv
// dense_input_framer
//   Gathers a serial stream of signed fixed-point samples into a parallel
//   INPUT_SIZE-element vector for the dense layer. A fill buffer and a hold
//   register give double buffering. Valid/ready handshakes are used on both
//   sides. dense_valid_o is the accepted-vector strobe delayed by LATENCY
//   cycles, so that it lines up with the dense layer output.
// Ports
//   clk_i          clock, rising edge
//   reset_i        synchronous, active-high reset
//   in_data_i      serial input sample (WIDTH bits, signed, passed bit-exact)
//   in_valid_i     in_data_i valid
//   in_last_i      final sample of the frame (qualified by the accept)
//   in_ready_o     framer can accept a sample this cycle
//   vec_data_o     assembled vector; element i at [i*WIDTH +: WIDTH],
//                  element 0 = first sample received
//   vec_valid_o    vec_data_o holds an unconsumed vector
//   vec_ready_i    consumer takes vec_data_o this cycle
//   short_frame_o  1-cycle pulse after a frame is closed early by in_last_i
//   dense_valid_o  (vec_valid_o & vec_ready_i) delayed by LATENCY cycles
module dense_input_framer #(
   parameter int unsigned WIDTH      = 17,
   parameter int unsigned INPUT_SIZE = 32,
   parameter int unsigned LATENCY    = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [WIDTH-1:0]              in_data_i,
   input  logic                          in_valid_i,
   input  logic                          in_last_i,
   output logic                          in_ready_o,
   output logic [INPUT_SIZE*WIDTH-1:0]   vec_data_o,
   output logic                          vec_valid_o,
   input  logic                          vec_ready_i,
   output logic                          short_frame_o,
   output logic                          dense_valid_o
);

   localparam int unsigned CW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam int unsigned VW = INPUT_SIZE * WIDTH;

   logic [CW-1:0]      count_q, count_d;
   logic [VW-1:0]      fill_q, fill_d;
   logic [VW-1:0]      vec_q, vec_d;
   logic [VW-1:0]      frame_c;
   logic               fill_full_q, fill_full_d;
   logic               vec_valid_q, vec_valid_d;
   logic               short_q, short_d;
   logic [LATENCY-1:0] dv_q, dv_d;

   logic accept;
   logic close;
   logic hold_free;
   logic handshake;

   assign in_ready_o = ~fill_full_q;
   assign accept     = in_valid_i & ~fill_full_q;
   assign close      = accept & (in_last_i | (count_q == CW'(INPUT_SIZE - 1)));
   assign handshake  = vec_valid_q & vec_ready_i;
   assign hold_free  = ~vec_valid_q | vec_ready_i;

   // Frame as it looks with the current sample in slot count_q.
   // Slots above count_q read as zero, which gives the zero padding on an early close.
   always_comb begin
      frame_c = '0;
      for (int i = 0; i < int'(INPUT_SIZE); i++) begin
         if (CW'(i) < count_q) begin
            frame_c[i*WIDTH +: WIDTH] = fill_q[i*WIDTH +: WIDTH];
         end else if (CW'(i) == count_q) begin
            frame_c[i*WIDTH +: WIDTH] = in_data_i;
         end
      end
   end

   // Next-state logic: fill buffer, hold register, count, pulses.
   always_comb begin
      count_d     = count_q;
      fill_d      = fill_q;
      fill_full_d = fill_full_q;
      vec_d       = vec_q;
      vec_valid_d = vec_valid_q & ~vec_ready_i;
      short_d     = 1'b0;
      dv_d        = (dv_q << 1) | LATENCY'(handshake);

      if (accept) begin
         fill_d  = frame_c;
         count_d = close ? '0 : count_q + CW'(1);
         short_d = in_last_i & (count_q != CW'(INPUT_SIZE - 1));
      end

      // A parked frame and a new close never coincide: in_ready_o is low while parked.
      if (fill_full_q && hold_free) begin
         vec_d       = fill_q;
         vec_valid_d = 1'b1;
         fill_full_d = 1'b0;
      end else if (close) begin
         if (hold_free) begin
            vec_d       = frame_c;
            vec_valid_d = 1'b1;
         end else begin
            fill_full_d = 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q     <= '0;
         fill_q      <= '0;
         fill_full_q <= 1'b0;
         vec_q       <= '0;
         vec_valid_q <= 1'b0;
         short_q     <= 1'b0;
         dv_q        <= '0;
      end else begin
         count_q     <= count_d;
         fill_q      <= fill_d;
         fill_full_q <= fill_full_d;
         vec_q       <= vec_d;
         vec_valid_q <= vec_valid_d;
         short_q     <= short_d;
         dv_q        <= dv_d;
      end
   end

   assign vec_data_o    = vec_q;
   assign vec_valid_o   = vec_valid_q;
   assign short_frame_o = short_q;
   assign dense_valid_o = dv_q[LATENCY-1];

endmodule

// File: tb/tb_dense_input_framer.sv
// Testbench for dense_input_framer (WIDTH=8, INPUT_SIZE=4, LATENCY=3).
// A queue-level reference model predicts every output each cycle. It holds
// the frame being gathered, the completed vectors awaiting the consumer, and
// a history of accepted-vector strobes.
module tb_dense_input_framer;

   localparam int unsigned W = 8;
   localparam int unsigned N = 4;
   localparam int unsigned L = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_last;
   logic           in_ready;
   logic [N*W-1:0] vec_data;
   logic           vec_valid;
   logic           vec_ready;
   logic           short_frame;
   logic           dense_valid;

   always #5 clk = ~clk;

   dense_input_framer #(.WIDTH(W), .INPUT_SIZE(N), .LATENCY(L)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .in_data_i     (in_data),
      .in_valid_i    (in_valid),
      .in_last_i     (in_last),
      .in_ready_o    (in_ready),
      .vec_data_o    (vec_data),
      .vec_valid_o   (vec_valid),
      .vec_ready_i   (vec_ready),
      .short_frame_o (short_frame),
      .dense_valid_o (dense_valid)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   int             cur[$];
   logic [N*W-1:0] pend[$];
   logic [L-1:0]   dv_m = '0;
   logic           short_m = 1'b0;
   logic [N*W-1:0] got[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock with the inputs currently driven, then the model update and the checks.
   task automatic step();
      bit             acc;
      bit             hs;
      logic [N*W-1:0] v;
      if (!reset && vec_valid && vec_ready) got.push_back(vec_data);
      @(posedge clk);
      if (reset) begin
         cur.delete();
         pend.delete();
         dv_m    = '0;
         short_m = 1'b0;
      end else begin
         acc     = in_valid && (pend.size() < 2);
         hs      = (pend.size() > 0) && vec_ready;
         dv_m    = {dv_m[L-2:0], hs};
         short_m = 1'b0;
         if (hs) void'(pend.pop_front());
         if (acc) begin
            cur.push_back(int'(in_data));
            if (cur.size() == N || in_last) begin
               v = '0;
               for (int i = 0; i < cur.size(); i++) v[i*W +: W] = W'(cur[i]);
               pend.push_back(v);
               short_m = (cur.size() < N);
               cur.delete();
            end
         end
      end
      #1;
      check_eq("in_ready",    32'(in_ready),    32'(pend.size() < 2));
      check_eq("vec_valid",   32'(vec_valid),   32'(pend.size() > 0));
      if (pend.size() > 0) check_eq("vec_data", 32'(vec_data), 32'(pend[0]));
      check_eq("short_frame", 32'(short_frame), 32'(short_m));
      check_eq("dense_valid", 32'(dense_valid), 32'(dv_m[L-1]));
   endtask

   task automatic send(input logic [W-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      step();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      reset     = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      vec_ready = 1'b0;

      // 1. Reset
      step();
      step();
      reset = 1'b0;
      check_eq("rst_vec_data", 32'(vec_data), 32'h0);

      // 2. Full frame
      vec_ready = 1'b1;
      for (int i = 1; i <= 4; i++) send(W'(i), 1'b0);
      check_eq("full_vec", 32'(vec_data), 32'h04030201);
      idle(5);

      // 3. Short frame then a full signed frame
      send(8'd5, 1'b0);
      send(8'd6, 1'b1);
      check_eq("short_vec", 32'(vec_data), 32'h00000605);
      check_eq("short_pulse", 32'(short_frame), 32'h1);
      send(8'hFF, 1'b0);
      send(8'hFE, 1'b0);
      send(8'hFD, 1'b0);
      send(8'hFC, 1'b0);
      check_eq("neg_vec", 32'(vec_data), 32'hFCFDFEFF);
      idle(4);

      // 4. Backpressure
      vec_ready = 1'b0;
      for (int i = 10; i <= 17; i++) send(W'(i), 1'b0);
      check_eq("bp_hold", 32'(vec_data), 32'h0D0C0B0A);
      check_eq("bp_in_ready", 32'(in_ready), 32'h0);
      send(8'd18, 1'b0);
      send(8'd18, 1'b0);
      in_valid  = 1'b0;
      vec_ready = 1'b1;
      step();
      vec_ready = 1'b0;
      check_eq("bp_next", 32'(vec_data), 32'h11100F0E);
      check_eq("bp_ready_back", 32'(in_ready), 32'h1);
      idle(2);
      vec_ready = 1'b1;
      idle(5);

      // 5. Reset mid-frame with strobes still in the dense_valid pipe
      for (int i = 21; i <= 24; i++) send(W'(i), 1'b0);
      send(8'd7, 1'b0);
      send(8'd8, 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      step();
      reset = 1'b0;
      got.delete();
      for (int i = 1; i <= 4; i++) send(W'(i), 1'b0);
      idle(6);
      check_eq("rst_mid_count", 32'(got.size()), 32'd1);
      if (got.size() > 0) check_eq("rst_mid_vec", 32'(got[0]), 32'h04030201);

      // 6. Back-to-back frames
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < 4; i++) send(W'(f*16 + i + 40), 1'b0);
      idle(6);

      // Randomized traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 299) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         in_last   = ($urandom_range(0, 9) == 0);
         in_data   = W'($urandom);
         vec_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      reset     = 1'b0;
      vec_ready = 1'b1;
      idle(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
